// File: rtl/dc_huffman_encoder_if.sv
// Handshake and result bundle for the DC Huffman encoder.
// The slave modport is the encoder side; master is the producer/consumer side.
interface dc_huffman_encoder_if #(
    parameter int COEF_W   = 11,
    parameter int NUM_COMP = 3
);
    localparam int CID_W = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] dc_in;
    logic [CID_W-1:0]         comp_id;
    logic                     restart;
    logic                     out_valid;
    logic                     out_ready;
    logic [10:0]              huff_code;
    logic [3:0]               huff_len;
    logic [COEF_W-1:0]        amp_bits;
    logic [3:0]               amp_len;
    logic [4:0]               total_len;
    logic                     err;

    modport master (
        output in_valid, dc_in, comp_id, restart, out_ready,
        input  in_ready, out_valid, huff_code, huff_len, amp_bits, amp_len, total_len, err
    );

    modport slave (
        input  in_valid, dc_in, comp_id, restart, out_ready,
        output in_ready, out_valid, huff_code, huff_len, amp_bits, amp_len, total_len, err
    );
endinterface

// File: rtl/dc_huffman_encoder.sv
// JPEG DC coefficient encoder: per-component DPCM difference (S1) followed by
// category, Huffman table lookup and amplitude bits (S2), with valid/ready flow control.
module dc_huffman_encoder #(
    parameter int COEF_W     = 11,
    parameter int NUM_COMP   = 3,
    parameter int LUMA_COMPS = 1
) (
    input logic                 clk,
    input logic                 rst,
    dc_huffman_encoder_if.slave bus
);
    localparam int DW = COEF_W + 1;

    logic [COEF_W-1:0] pred_q [NUM_COMP];
    logic [COEF_W-1:0] pred_d [NUM_COMP];

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_diff_q, s1_diff_d;
    logic          s1_chroma_q, s1_chroma_d;
    logic          s1_err_q, s1_err_d;

    logic              out_valid_q, out_valid_d;
    logic [10:0]       huff_code_q, huff_code_d;
    logic [3:0]        huff_len_q, huff_len_d;
    logic [COEF_W-1:0] amp_bits_q, amp_bits_d;
    logic [3:0]        amp_len_q, amp_len_d;
    logic [4:0]        total_len_q, total_len_d;
    logic              err_q, err_d;

    logic              s2_adv, s1_adv, accept, bad_id;
    logic [COEF_W-1:0] pred_sel;
    logic [DW-1:0]     mag;
    logic [COEF_W-1:0] amp_src;
    logic [3:0]        cat, hlen;
    logic [10:0]       code_w;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = !rst && s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: difference against the component predictor, predictor update.
    // Out-of-range ids never match the loop, so they see a zero predictor.
    always_comb begin
        bad_id   = (int'(bus.comp_id) >= NUM_COMP);
        pred_sel = '0;
        for (int unsigned i = 0; i < NUM_COMP; i++) begin
            if (int'(bus.comp_id) == int'(i)) pred_sel = pred_q[i];
        end
        if (bus.restart) pred_sel = '0;

        pred_d      = pred_q;
        s1_valid_d  = s1_valid_q;
        s1_diff_d   = s1_diff_q;
        s1_chroma_d = s1_chroma_q;
        s1_err_d    = s1_err_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_diff_d   = {bus.dc_in[COEF_W-1], bus.dc_in} - {pred_sel[COEF_W-1], pred_sel};
                s1_chroma_d = bad_id || (int'(bus.comp_id) >= LUMA_COMPS);
                s1_err_d    = bad_id;
                if (bus.restart) begin
                    for (int unsigned i = 0; i < NUM_COMP; i++) pred_d[i] = '0;
                end
                for (int unsigned i = 0; i < NUM_COMP; i++) begin
                    if (int'(bus.comp_id) == int'(i)) pred_d[i] = bus.dc_in;
                end
            end
        end
    end

    // Stage 2: category, amplitude bits and table lookup.
    always_comb begin
        mag = s1_diff_q[DW-1] ? (DW'(0) - s1_diff_q) : s1_diff_q;
        cat = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (mag[i]) cat = 4'(i + 1);
        end

        // Negative differences emit the low bits of diff-1 (one's complement form).
        amp_src = COEF_W'(s1_diff_q - (s1_diff_q[DW-1] ? DW'(1) : DW'(0)));
        amp_bits_d = '0;
        for (int unsigned i = 0; i < COEF_W; i++) begin
            amp_bits_d[i] = amp_src[i] && (i < 32'(cat));
        end

        // Long codes of both tables are a run of ones terminated by a zero.
        if (!s1_chroma_q) begin
            if (cat == 4'd0) begin
                hlen   = 4'd2;
                code_w = '0;
            end else if (cat <= 4'd5) begin
                hlen   = 4'd3;
                code_w = 11'(cat) + 11'd1;
            end else begin
                hlen   = cat - 4'd2;
                code_w = (11'd1 << hlen) - 11'd2;
            end
        end else begin
            if (cat == 4'd0) begin
                hlen   = 4'd2;
                code_w = '0;
            end else if (cat <= 4'd2) begin
                hlen   = 4'd2;
                code_w = 11'(cat);
            end else begin
                hlen   = cat;
                code_w = (11'd1 << cat) - 11'd2;
            end
        end

        out_valid_d = out_valid_q;
        huff_code_d = huff_code_q;
        huff_len_d  = huff_len_q;
        amp_len_d   = amp_len_q;
        total_len_d = total_len_q;
        err_d       = err_q;
        if (!s2_adv) amp_bits_d = amp_bits_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            huff_code_d = code_w;
            huff_len_d  = hlen;
            amp_len_d   = cat;
            total_len_d = 5'(hlen) + 5'(cat);
            err_d       = s1_valid_q && s1_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q      <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_chroma_q <= 1'b0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            huff_code_q <= '0;
            huff_len_q  <= '0;
            amp_bits_q  <= '0;
            amp_len_q   <= '0;
            total_len_q <= '0;
            err_q       <= 1'b0;
        end else begin
            pred_q      <= pred_d;
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_chroma_q <= s1_chroma_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            huff_code_q <= huff_code_d;
            huff_len_q  <= huff_len_d;
            amp_bits_q  <= amp_bits_d;
            amp_len_q   <= amp_len_d;
            total_len_q <= total_len_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.huff_code = huff_code_q;
    assign bus.huff_len  = huff_len_q;
    assign bus.amp_bits  = amp_bits_q;
    assign bus.amp_len   = amp_len_q;
    assign bus.total_len = total_len_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dc_huffman_encoder.sv
// Directed plus randomized bench for dc_huffman_encoder against a table-driven
// JPEG DC reference model with an expected-result queue.
module tb_dc_huffman_encoder;
    localparam int COEF_W     = 11;
    localparam int NUM_COMP   = 3;
    localparam int LUMA_COMPS = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dc_huffman_encoder_if #(.COEF_W(COEF_W), .NUM_COMP(NUM_COMP)) bus ();

    dc_huffman_encoder #(
        .COEF_W    (COEF_W),
        .NUM_COMP  (NUM_COMP),
        .LUMA_COMPS(LUMA_COMPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int code; int hlen; int amp; int alen; int tot; int err; int acc;
    } res_t;

    int LU_CODE [12] = '{0, 2, 3, 4, 5, 6, 14, 30, 62, 126, 254, 510};
    int LU_LEN  [12] = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};
    int CH_CODE [12] = '{0, 1, 2, 6, 14, 30, 62, 126, 254, 510, 1022, 2046};
    int CH_LEN  [12] = '{2, 2, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

    res_t exp_q[$];
    res_t got_q[$];
    int   pred [NUM_COMP];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   acc_now;
    bit   lat_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int dc, input int cid, input bit rs);
        res_t r;
        int   p, d, a, cat;
        bit   bad, chroma;
        bad = (cid >= NUM_COMP);
        p   = (rs || bad) ? 0 : pred[cid];
        d   = dc - p;
        a   = (d < 0) ? -d : d;
        cat = 0;
        while ((1 << cat) <= a) cat++;
        chroma = bad || (cid >= LUMA_COMPS);
        r.code = chroma ? CH_CODE[cat] : LU_CODE[cat];
        r.hlen = chroma ? CH_LEN[cat] : LU_LEN[cat];
        r.amp  = (d >= 0) ? d : d + (1 << cat) - 1;
        r.alen = cat;
        r.tot  = r.hlen + r.alen;
        r.err  = bad ? 1 : 0;
        r.acc  = cyc;
        if (rs) foreach (pred[i]) pred[i] = 0;
        if (!bad) pred[cid] = dc;
        exp_q.push_back(r);
    endtask

    // One clock: observe handshakes on the falling edge, return #1 after the rising edge.
    task automatic tick();
        res_t e, g;
        @(negedge clk);
        acc_now = 0;
        if (rst) begin
            exp_q.delete();
            foreach (pred[i]) pred[i] = 0;
        end else begin
            if (bus.out_valid) begin
                chk("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("huff_code", bus.huff_code, e.code);
                    chk("huff_len", bus.huff_len, e.hlen);
                    chk("amp_bits", bus.amp_bits, e.amp);
                    chk("amp_len", bus.amp_len, e.alen);
                    chk("total_len", bus.total_len, e.tot);
                    chk("err", bus.err, e.err);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        if (lat_mode) chk("latency", cyc - e.acc, 2);
                    end
                end
                if (bus.out_ready) begin
                    g.code = int'(bus.huff_code); g.hlen = int'(bus.huff_len);
                    g.amp  = int'(bus.amp_bits);  g.alen = int'(bus.amp_len);
                    g.tot  = int'(bus.total_len); g.err  = int'(bus.err);
                    g.acc  = cyc;
                    got_q.push_back(g);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_now = 1;
                model_accept(int'(bus.dc_in), int'(bus.comp_id), bus.restart);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int dc, input int cid, input bit rs);
        bit done;
        bus.in_valid = 1'b1;
        bus.dc_in    = COEF_W'(dc);
        bus.comp_id  = 2'(cid);
        bus.restart  = rs;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            done = acc_now;
        end
        if (!done) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) done = 1;
            else tick();
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int n_acc, n_sent, dcs[6], cids[6];
        bit ok;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.dc_in = '0; bus.comp_id = '0;
        bus.restart = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_huff_code", bus.huff_code, 0);
        chk("rst_amp_bits", bus.amp_bits, 0);
        chk("rst_total_len", bus.total_len, 0);
        chk("rst_err", bus.err, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Luma sequence with latency
        bus.out_ready = 1'b1;
        lat_mode = 1;
        got_q.delete();
        send(5, 0, 0);
        send(2, 0, 0);
        drain();
        lat_mode = 0;
        chk("l1_code", got_q[0].code, 'b100);
        chk("l1_amp", got_q[0].amp, 'b101);
        chk("l1_alen", got_q[0].alen, 3);
        chk("l2_code", got_q[1].code, 'b011);
        chk("l2_amp", got_q[1].amp, 0);
        chk("l2_alen", got_q[1].alen, 2);
        chk("l_back_to_back", got_q[1].acc - got_q[0].acc, 1);

        // Chroma and zero difference
        got_q.delete();
        send(-1, 1, 0);
        send(-1, 1, 0);
        drain();
        chk("c1_code", got_q[0].code, 'b01);
        chk("c1_hlen", got_q[0].hlen, 2);
        chk("c1_amp", got_q[0].amp, 0);
        chk("c1_tot", got_q[0].tot, 3);
        chk("c2_code", got_q[1].code, 0);
        chk("c2_alen", got_q[1].alen, 0);

        // Maximum category
        got_q.delete();
        send(1023, 0, 0);
        send(-1023, 0, 0);
        drain();
        chk("max_alen", got_q[1].alen, 11);
        chk("max_code", got_q[1].code, 'b111111110);
        chk("max_hlen", got_q[1].hlen, 9);
        chk("max_amp", got_q[1].amp, 1);
        chk("max_tot", got_q[1].tot, 20);

        // Restart and out-of-range component
        got_q.delete();
        send(100, 0, 0);
        send(50, 1, 0);
        send(3, 1, 1);
        send(3, 0, 0);
        send(7, 3, 0);
        send(3, 0, 0);
        send(3, 1, 0);
        drain();
        chk("rs_code", got_q[2].code, 'b10);
        chk("rs_amp", got_q[2].amp, 3);
        chk("rs2_code", got_q[3].code, 'b011);
        chk("rs2_amp", got_q[3].amp, 3);
        chk("bad_err", got_q[4].err, 1);
        chk("bad_amp", got_q[4].amp, 7);
        chk("bad_code", got_q[4].code, 'b110);
        chk("bad_nopred0", got_q[5].alen, 0);
        chk("bad_nopred1", got_q[6].alen, 0);

        // Backpressure: out_ready low for 4 cycles while streaming 6 inputs
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            dcs[i]  = int'($urandom_range(2046)) - 1023;
            cids[i] = int'($urandom_range(2));
        end
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.dc_in    = COEF_W'(dcs[n_acc]);
            bus.comp_id  = 2'(cids[n_acc]);
            tick();
            if (acc_now) n_acc++;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30 && n_acc < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.dc_in    = COEF_W'(dcs[n_acc]);
            bus.comp_id  = 2'(cids[n_acc]);
            tick();
            if (acc_now) n_acc++;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_sent", n_acc, 6);
        drain();
        chk("bp_count", got_q.size(), 6);

        // Randomized traffic with random backpressure
        n_sent = 0;
        for (int k = 0; k < 3000 && n_sent < 200; k++) begin
            int cid;
            cid = int'($urandom_range(3));
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.dc_in     = COEF_W'(int'($urandom_range(2046)) - 1023);
            bus.comp_id   = 2'(cid);
            bus.restart   = (cid < NUM_COMP) && ($urandom_range(7) == 0);
            tick();
            if (acc_now) n_sent++;
        end
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_sent", n_sent, 200);
        drain();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.comp_id = 2'(0);
        bus.dc_in = COEF_W'(9);
        tick();
        bus.dc_in = COEF_W'(11);
        tick();
        bus.in_valid = 1'b0;
        chk("full_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        got_q.delete();
        bus.out_ready = 1'b1;
        send(4, 0, 0);
        drain();
        for (int k = 0; k < 5; k++) tick();
        chk("post_rst_count", got_q.size(), 1);
        chk("post_rst_code", got_q[0].code, 'b100);
        chk("post_rst_amp", got_q[0].amp, 4);
        chk("post_rst_alen", got_q[0].alen, 3);

        ok = (errors == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
